// File: rtl/instr_register_pipe_if.sv
// Bus bundle for instr_register_pipe: write handshake, read port, clear control and status.
`default_nettype none

interface instr_register_pipe_if #(
  parameter int OP_W  = 32,
  parameter int DEPTH = 32
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RES_W  = 2 * OP_W;
  localparam int ENT_W  = 3 + 2 * OP_W + RES_W + 2;

  logic              wr_valid;
  logic              wr_ready;
  logic              wr_auto;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_opcode;
  logic [OP_W-1:0]   wr_a;
  logic [OP_W-1:0]   wr_b;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [ENT_W-1:0]  rd_data;
  logic              clr_req;
  logic              busy;
  logic [ADDR_W-1:0] wp;

  modport master (
    output wr_valid, wr_auto, wr_addr, wr_opcode, wr_a, wr_b, rd_en, rd_addr, clr_req,
    input  wr_ready, rd_valid, rd_data, busy, wp
  );

  modport slave (
    input  wr_valid, wr_auto, wr_addr, wr_opcode, wr_a, wr_b, rd_en, rd_addr, clr_req,
    output wr_ready, rd_valid, rd_data, busy, wp
  );
endinterface

`default_nettype wire

// File: rtl/instr_register_pipe.sv
// Decoded-instruction store: two-stage write pipeline with full-precision ALU,
// registered read port and a sequential one-entry-per-cycle bulk clear.
`default_nettype none

module instr_register_pipe #(
  parameter int OP_W   = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int RES_W  = 2 * OP_W
) (
  input  logic                clk,
  input  logic                reset,
  instr_register_pipe_if.slave bus
);
  localparam int ENT_W = 3 + 2 * OP_W + RES_W + 2;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  localparam logic [2:0] OP_PASSA = 3'd1;
  localparam logic [2:0] OP_PASSB = 3'd2;
  localparam logic [2:0] OP_ADD   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_MULT  = 3'd5;
  localparam logic [2:0] OP_DIV   = 3'd6;
  localparam logic [2:0] OP_MOD   = 3'd7;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] wp_q, wp_d;

  logic              s1_valid_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic [2:0]        s1_op_q;
  logic [OP_W-1:0]   s1_a_q;
  logic [OP_W-1:0]   s1_b_q;

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic              rd_valid_q;
  logic [ENT_W-1:0]  rd_data_q;

  logic                    accept;
  logic signed [RES_W-1:0] a_ext, b_ext, b_den, result;
  logic                    b_zero, dz;
  logic [ENT_W-1:0]        entry;

  assign bus.wr_ready = (state_q == ST_IDLE) && !reset;
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign bus.busy     = (state_q == ST_CLEAR);
  assign bus.wp       = wp_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wp_d    = wp_q;
    if (accept && bus.wr_auto) wp_d = wp_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      default: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          wp_d    = '0;
        end
      end
    endcase
  end

  // Divisor is forced non-zero so the divider never sees b==0; dz masks the result instead.
  always_comb begin
    a_ext  = {{(RES_W - OP_W){s1_a_q[OP_W-1]}}, s1_a_q};
    b_ext  = {{(RES_W - OP_W){s1_b_q[OP_W-1]}}, s1_b_q};
    b_zero = (s1_b_q == '0);
    b_den  = b_zero ? RES_W'(1) : b_ext;
    result = '0;
    dz     = 1'b0;
    case (s1_op_q)
      OP_PASSA: result = a_ext;
      OP_PASSB: result = b_ext;
      OP_ADD:   result = a_ext + b_ext;
      OP_SUB:   result = a_ext - b_ext;
      OP_MULT:  result = a_ext * b_ext;
      OP_DIV: begin
        if (b_zero) dz = 1'b1;
        else        result = a_ext / b_den;
      end
      OP_MOD: begin
        if (b_zero) dz = 1'b1;
        else        result = a_ext % b_den;
      end
      default:  result = '0;
    endcase
    entry = {s1_op_q, s1_a_q, s1_b_q, result, dz, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wp_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_op_q    <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wp_q       <= wp_d;
      s1_valid_q <= accept;
      if (accept) begin
        s1_addr_q <= bus.wr_auto ? wp_q : bus.wr_addr;
        s1_op_q   <= bus.wr_opcode;
        s1_a_q    <= bus.wr_a;
        s1_b_q    <= bus.wr_b;
      end
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_data_q <= mem_q[bus.rd_addr];
      if (s1_valid_q) mem_q[s1_addr_q] <= entry;
      // Later assignment takes priority: a clear beats a commit to the same index.
      if (state_q == ST_CLEAR) mem_q[idx_q] <= '0;
    end
  end
endmodule

`default_nettype wire
